// File: rtl/seg_display_port_if.sv
// Bus between the CPU output-port path and the 7-segment display port.
// The CPU side uses the master modport; the display port uses the slave modport.
//
// Handshake: wr_en is a one-cycle write strobe qualifying data_in. There is
// no ready: every write is accepted. A write arriving while a conversion is
// running lands in a one-deep pending slot, and a later write overwrites it.
// done is the output-valid pulse: it is high for exactly the one cycle in
// which hex_out/ovf have just taken a new value. busy covers both a running
// conversion and a pending write.
interface seg_display_port_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 2
) ();
  logic                    wr_en;
  logic [DATA_W-1:0]       data_in;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic [1:0]              dbg_state;

  modport master (
    output wr_en, data_in,
    input  hex_out, busy, done, ovf, dbg_state
  );

  modport slave (
    input  wr_en, data_in,
    output hex_out, busy, done, ovf, dbg_state
  );
endinterface

// File: rtl/seg_display_port.sv
// seg_display_port: binary-to-BCD display port for NUM_DIGITS active-low
// 7-segment digits. Conversion is sequential shift-add-3, one input bit per
// clock. Values of 10^NUM_DIGITS or more show dashes and raise ovf.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits
// above digit 0). Without it every digit shows a zero-padded numeral.
// The FSM state is exposed on bus.dbg_state (0=IDLE, 1=SHIFT, 2=DONE).
module seg_display_port #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 2
) (
  input  logic               clk,
  input  logic               resetn,
  seg_display_port_if.slave  bus
);

  // ceil(DATA_W*log10(2)) + 1 digits, in integer arithmetic
  localparam int BCD_DIGITS = (DATA_W * 30103 + 99999) / 100000 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SR_W       = BCD_W + DATA_W;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int MAXD       = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int PAD_W      = 4 * MAXD;
  localparam int HEX_W      = 7 * NUM_DIGITS;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Display content after reset: a zero, blanked above digit 0 when blanking is on
  function automatic logic [HEX_W-1:0] reset_hex();
    logic [HEX_W-1:0] h;
    h = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
      h[7*k +: 7] = (k == 0) ? SEG_ZERO : SEG_BLANK;
`else
      h[7*k +: 7] = SEG_ZERO;
`endif
    end
    return h;
  endfunction

  localparam logic [HEX_W-1:0] RST_HEX = reset_hex();

  state_t              r_state;
  logic [SR_W-1:0]     r_sr;        // {bcd, bin} shift register
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pend_valid;
  logic [DATA_W-1:0]   r_pend_data;
  logic [HEX_W-1:0]    r_hex;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;

  logic [BCD_W-1:0]    w_bcd_adj;
  logic [PAD_W-1:0]    w_bcd_pad;
  logic                w_ovf;
  logic [HEX_W-1:0]    w_hex_next;
  logic                w_last_shift;
  logic [DATA_W-1:0]   w_reload;

  // Add-3 correction on every BCD nibble of 5 or more, ahead of the shift
  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_sr[DATA_W + 4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = 4'(r_sr[DATA_W + 4*i +: 4] + 4'd3);
      else
        w_bcd_adj[4*i +: 4] = r_sr[DATA_W + 4*i +: 4];
    end
  end

  assign w_bcd_pad    = PAD_W'(r_sr[SR_W-1:DATA_W]);
  assign w_last_shift = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_reload     = bus.wr_en ? bus.data_in : r_pend_data;

  // Overflow detect and segment image of the finished BCD result
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic v_lead;
    v_lead = 1'b1;
`endif
    w_ovf = 1'b0;
    for (int k = 0; k < MAXD; k++) begin
      if (k >= NUM_DIGITS && w_bcd_pad[4*k +: 4] != 4'd0)
        w_ovf = 1'b1;
    end
    w_hex_next = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (w_ovf)
        w_hex_next[7*k +: 7] = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
      else if (v_lead && k != 0 && w_bcd_pad[4*k +: 4] == 4'd0)
        w_hex_next[7*k +: 7] = SEG_BLANK;
      else begin
        v_lead = 1'b0;
        w_hex_next[7*k +: 7] = seg7(w_bcd_pad[4*k +: 4]);
      end
`else
      else
        w_hex_next[7*k +: 7] = seg7(w_bcd_pad[4*k +: 4]);
`endif
    end
  end

  // Conversion FSM with registered display, status and pending write slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_hex        <= RST_HEX;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.wr_en) begin
            r_sr    <= {{BCD_W{1'b0}}, bus.data_in};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sr  <= {w_bcd_adj, r_sr[DATA_W-1:0]} << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last_shift)
            r_state <= S_DONE;
          if (bus.wr_en) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= bus.data_in;
          end
        end
        S_DONE: begin
          r_hex  <= w_hex_next;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
          // A write in this very cycle is newer than the pending one
          if (bus.wr_en || r_pend_valid) begin
            r_sr         <= {{BCD_W{1'b0}}, w_reload};
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_state      <= S_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hex_out   = r_hex;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;

endmodule
